// File: rtl/hd_query_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : hd_query_sequencer
// Brief    : Byte-stream query front end and control sequencer for the
//            hyperdimensional language classifier core. Optional scoring
//            against a per-text label is enabled by defining HD_SCORE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hd_query_sequencer #(
    parameter int N              = 10000,
    parameter int MAXLETTERS     = 27,
    parameter int NUMLANG        = 22,
    parameter int DIMS_PER_CYCLE = 1,
    parameter int DRAIN_CYCLES   = 2,
    parameter int WAIT_TIMEOUT   = 1024,
    parameter int CNT_W          = 16,
    localparam int LW            = $clog2(MAXLETTERS),
    localparam int IW            = $clog2(N),
    localparam int CW            = $clog2(NUMLANG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             char_valid,
    input  logic [7:0]       char_data,
    input  logic             char_last,
    input  logic [CW-1:0]    label_in,
    output logic             char_ready,
    output logic             letterReady,
    output logic [LW-1:0]    inputLetter,
    output logic             textDone,
    output logic             rst_RI,
    output logic             computeAngle,
    output logic [IW-1:0]    index,
    output logic             argmax,
    input  logic             done,
    input  logic [CW-1:0]    bestMatchID,
    output logic             res_valid,
    output logic [CW-1:0]    res_id,
    output logic             res_match,
    output logic             res_timeout,
    output logic [CNT_W-1:0] unknown_cnt,
    output logic [CNT_W-1:0] test_cnt,
    output logic [CNT_W-1:0] correct_cnt
);

    localparam int TMAX = (WAIT_TIMEOUT > DRAIN_CYCLES) ? WAIT_TIMEOUT : DRAIN_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LETTER  = 3'd1,
        S_TXTDONE = 3'd2,
        S_START   = 3'd3,
        S_COUNT   = 3'd4,
        S_DRAIN   = 3'd5,
        S_WAIT    = 3'd6,
        S_RESULT  = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic              letter_ready_q, letter_ready_d;
    logic [LW-1:0]     input_letter_q, input_letter_d;
    logic [IW-1:0]     index_q, index_d;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic [CW-1:0]     res_id_q, res_id_d;
    logic              res_match_q, res_match_d;
    logic              res_timeout_q, res_timeout_d;
    logic [CNT_W-1:0]  unknown_q, unknown_d;
    logic [CNT_W-1:0]  test_q, test_d;
    logic [CNT_W-1:0]  correct_q, correct_d;

    logic              accept;
    logic              is_space;
    logic              is_lower;
    logic              label_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Reset gates the handshake so no byte is offered acceptance while held.
    assign char_ready = rst && ((state_q == S_IDLE) || (state_q == S_LETTER));
    assign accept     = char_valid && char_ready;
    assign is_space   = (char_data == 8'h20);
    assign is_lower   = (char_data >= 8'h61) && (char_data <= 8'h7a);

`ifdef HD_SCORE_EN
    logic [CW-1:0] label_q, label_d;

    always_comb begin
        label_d = label_q;
        if (accept && char_last) begin
            label_d = label_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            label_q <= '0;
        end else begin
            label_q <= label_d;
        end
    end

    assign label_hit = (label_q == bestMatchID);
`else
    logic unused_label;
    assign unused_label = ^label_in;
    assign label_hit    = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        letter_ready_d = 1'b0;
        input_letter_d = input_letter_q;
        index_d        = index_q;
        tmr_d          = tmr_q;
        res_id_d       = res_id_q;
        res_match_d    = res_match_q;
        res_timeout_d  = res_timeout_q;
        unknown_d      = unknown_q;
        test_d         = test_q;
        correct_d      = correct_q;

        case (state_q)
            S_IDLE, S_LETTER: begin
                if (accept) begin
                    if (is_space) begin
                        letter_ready_d = 1'b1;
                        input_letter_d = LW'(MAXLETTERS - 1);
                    end else if (is_lower) begin
                        letter_ready_d = 1'b1;
                        input_letter_d = LW'(char_data - 8'h61);
                    end else begin
                        unknown_d = sat_inc(unknown_q);
                    end
                    state_d = char_last ? S_TXTDONE : S_LETTER;
                end
            end
            S_TXTDONE: begin
                index_d = '0;
                state_d = S_START;
            end
            S_START: begin
                index_d = '0;
                state_d = S_COUNT;
            end
            S_COUNT: begin
                if (index_q == IW'(N - DIMS_PER_CYCLE)) begin
                    index_d = '0;
                    tmr_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    index_d = index_q + IW'(DIMS_PER_CYCLE);
                end
            end
            S_DRAIN: begin
                if (tmr_q == TW'(DRAIN_CYCLES - 1)) begin
                    tmr_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_WAIT: begin
                // Result flags and statistics update on entry to RESULT so they
                // are already visible alongside the res_valid strobe.
                if (done) begin
                    res_id_d      = bestMatchID;
                    res_timeout_d = 1'b0;
                    res_match_d   = label_hit;
                    test_d        = sat_inc(test_q);
                    if (label_hit) begin
                        correct_d = sat_inc(correct_q);
                    end
                    state_d = S_RESULT;
                end else if (tmr_q == TW'(WAIT_TIMEOUT - 1)) begin
                    res_timeout_d = 1'b1;
                    res_match_d   = 1'b0;
                    test_d        = sat_inc(test_q);
                    state_d       = S_RESULT;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_RESULT: begin
                tmr_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            letter_ready_q <= 1'b0;
            input_letter_q <= '0;
            index_q        <= '0;
            tmr_q          <= '0;
            res_id_q       <= '0;
            res_match_q    <= 1'b0;
            res_timeout_q  <= 1'b0;
            unknown_q      <= '0;
            test_q         <= '0;
            correct_q      <= '0;
        end else begin
            state_q        <= state_d;
            letter_ready_q <= letter_ready_d;
            input_letter_q <= input_letter_d;
            index_q        <= index_d;
            tmr_q          <= tmr_d;
            res_id_q       <= res_id_d;
            res_match_q    <= res_match_d;
            res_timeout_q  <= res_timeout_d;
            unknown_q      <= unknown_d;
            test_q         <= test_d;
            correct_q      <= correct_d;
        end
    end

    assign letterReady  = letter_ready_q;
    assign inputLetter  = input_letter_q;
    assign textDone     = (state_q == S_TXTDONE);
    assign rst_RI       = (state_q != S_IDLE);
    assign computeAngle = (state_q == S_START);
    assign index        = index_q;
    assign argmax       = (state_q == S_DRAIN) && (tmr_q == '0);
    assign res_valid    = (state_q == S_RESULT);
    assign res_id       = res_id_q;
    assign res_match    = res_match_q;
    assign res_timeout  = res_timeout_q;
    assign unknown_cnt  = unknown_q;
    assign test_cnt     = test_q;
    assign correct_cnt  = correct_q;

endmodule
`default_nettype wire

// File: tb/tb_hd_query_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hd_query_sequencer
// Brief    : Directed self-checking bench for hd_query_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hd_query_sequencer;

    localparam int N          = 64;
    localparam int MAXLETTERS = 27;
    localparam int NUMLANG    = 22;
    localparam int DPC        = 4;
    localparam int DRAIN      = 2;
    localparam int TIMEOUT    = 100;
    localparam int CNT_W      = 16;
    localparam int LW         = 5;
    localparam int IW         = 6;
    localparam int CW         = 5;
`ifdef HD_SCORE_EN
    localparam logic SCORE = 1'b1;
`else
    localparam logic SCORE = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             char_valid;
    logic [7:0]       char_data;
    logic             char_last;
    logic [CW-1:0]    label_in;
    logic             char_ready;
    logic             letterReady;
    logic [LW-1:0]    inputLetter;
    logic             textDone;
    logic             rst_RI;
    logic             computeAngle;
    logic [IW-1:0]    index;
    logic             argmax;
    logic             done;
    logic [CW-1:0]    bestMatchID;
    logic             res_valid;
    logic [CW-1:0]    res_id;
    logic             res_match;
    logic             res_timeout;
    logic [CNT_W-1:0] unknown_cnt;
    logic [CNT_W-1:0] test_cnt;
    logic [CNT_W-1:0] correct_cnt;

    int n_cmp  = 0;
    int n_fail = 0;
    int early  = 0;

    hd_query_sequencer #(
        .N              (N),
        .MAXLETTERS     (MAXLETTERS),
        .NUMLANG        (NUMLANG),
        .DIMS_PER_CYCLE (DPC),
        .DRAIN_CYCLES   (DRAIN),
        .WAIT_TIMEOUT   (TIMEOUT),
        .CNT_W          (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .char_valid   (char_valid),
        .char_data    (char_data),
        .char_last    (char_last),
        .label_in     (label_in),
        .char_ready   (char_ready),
        .letterReady  (letterReady),
        .inputLetter  (inputLetter),
        .textDone     (textDone),
        .rst_RI       (rst_RI),
        .computeAngle (computeAngle),
        .index        (index),
        .argmax       (argmax),
        .done         (done),
        .bestMatchID  (bestMatchID),
        .res_valid    (res_valid),
        .res_id       (res_id),
        .res_match    (res_match),
        .res_timeout  (res_timeout),
        .unknown_cnt  (unknown_cnt),
        .test_cnt     (test_cnt),
        .correct_cnt  (correct_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Offer one byte for exactly one rising edge; returns on the following falling edge.
    task automatic send(input logic [7:0] b, input logic last);
        char_valid = 1'b1;
        char_data  = b;
        char_last  = last;
        @(negedge clk);
        char_valid = 1'b0;
        char_last  = 1'b0;
    endtask

    initial begin
        rst         = 1'b0;
        char_valid  = 1'b0;
        char_data   = 8'h00;
        char_last   = 1'b0;
        label_in    = '0;
        done        = 1'b0;
        bestMatchID = '0;

        // Reset
        repeat (3) step();
        chk("reset_flags", {char_ready, letterReady, textDone, rst_RI, computeAngle,
                            argmax, res_valid, res_match, res_timeout}, 32'd0);
        chk("reset_index", index, 32'd0);
        chk("reset_letter", inputLetter, 32'd0);
        chk("reset_res_id", res_id, 32'd0);
        chk("reset_counters", {unknown_cnt, test_cnt} | {16'd0, correct_cnt}, 32'd0);
        rst = 1'b1;
        step();
        chk("idle_char_ready", char_ready, 32'd1);
        chk("idle_rst_RI", rst_RI, 32'd0);

        // Query "ab c", label 5, core answers 5 (done held high throughout)
        label_in    = 5'd5;
        done        = 1'b1;
        bestMatchID = 5'd5;
        send(8'h61, 1'b0);
        chk("a_ready", letterReady, 32'd1);
        chk("a_letter", inputLetter, 32'd0);
        chk("a_rst_RI", rst_RI, 32'd1);
        send(8'h62, 1'b0);
        chk("b_ready", letterReady, 32'd1);
        chk("b_letter", inputLetter, 32'd1);
        send(8'h20, 1'b0);
        chk("sp_ready", letterReady, 32'd1);
        chk("sp_letter", inputLetter, 32'd26);
        send(8'h63, 1'b1);
        chk("c_ready", letterReady, 32'd1);
        chk("c_letter", inputLetter, 32'd2);
        chk("c_textDone", textDone, 32'd1);
        chk("c_char_ready", char_ready, 32'd0);
        step();
        chk("start_computeAngle", computeAngle, 32'd1);
        chk("start_index", index, 32'd0);
        chk("start_textDone", textDone, 32'd0);
        for (int k = 0; k < N / DPC; k++) begin
            step();
            chk("count_index", index, 32'(k * DPC));
        end
        step();
        chk("argmax_pulse", argmax, 32'd1);
        step();
        chk("drain2_argmax", argmax, 32'd0);
        chk("drain2_res_valid", res_valid, 32'd0);
        step();
        chk("wait_res_valid", res_valid, 32'd0);
        step();
        chk("q1_res_valid", res_valid, 32'd1);
        chk("q1_res_id", res_id, 32'd5);
        chk("q1_res_match", res_match, 32'(SCORE));
        chk("q1_res_timeout", res_timeout, 32'd0);
        chk("q1_test_cnt", test_cnt, 32'd1);
        chk("q1_correct_cnt", correct_cnt, 32'(SCORE));
        step();
        chk("q1_after_valid", res_valid, 32'd0);
        chk("q1_after_rst_RI", rst_RI, 32'd0);
        chk("q1_after_ready", char_ready, 32'd1);

        // Query "a1b", core never answers -> timeout
        done        = 1'b0;
        bestMatchID = 5'd9;
        label_in    = 5'd3;
        send(8'h61, 1'b0);
        chk("a1b_a_letter", inputLetter, 32'd0);
        send(8'h31, 1'b0);
        chk("a1b_1_ready", letterReady, 32'd0);
        chk("a1b_1_letter", inputLetter, 32'd0);
        chk("a1b_unknown", unknown_cnt, 32'd1);
        send(8'h62, 1'b1);
        chk("a1b_b_letter", inputLetter, 32'd1);
        chk("a1b_textDone", textDone, 32'd1);
        early = 0;
        repeat (119) begin
            step();
            if (res_valid) early++;
        end
        chk("to_early_valid", early, 32'd0);
        step();
        chk("to_res_valid", res_valid, 32'd1);
        chk("to_res_timeout", res_timeout, 32'd1);
        chk("to_res_match", res_match, 32'd0);
        chk("to_res_id", res_id, 32'd5);
        chk("to_test_cnt", test_cnt, 32'd2);
        chk("to_correct_cnt", correct_cnt, 32'(SCORE));
        step();
        chk("to_hold_timeout", res_timeout, 32'd1);
        chk("to_after_valid", res_valid, 32'd0);

        // Single-byte text "z", reset during COUNT
        done = 1'b1;
        send(8'h7a, 1'b1);
        chk("z_letter", inputLetter, 32'd25);
        chk("z_textDone", textDone, 32'd1);
        step();
        repeat (9) step();
        chk("mid_count_index", index, 32'd32);
        rst = 1'b0;
        step();
        chk("rstc_index", index, 32'd0);
        chk("rstc_rst_RI", rst_RI, 32'd0);
        chk("rstc_res_valid", res_valid, 32'd0);
        chk("rstc_counters", {unknown_cnt, test_cnt} | {16'd0, correct_cnt}, 32'd0);
        chk("rstc_flags", {res_match, res_timeout, char_ready}, 32'd0);
        rst = 1'b1;
        early = 0;
        repeat (30) begin
            step();
            if (res_valid) early++;
        end
        chk("rstc_no_result", early, 32'd0);
        chk("rstc_idle_ready", char_ready, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
